// File: rtl/pushbutton_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_pkg
// Description : Shared constants for the pushbutton conditioner.
//               Per-key debounce state encoding and the default debounce
//               window (10 ms at 100 MHz).
// Revision    : 1.0 - initial release
// ============================================================================
package pushbutton_pkg;

    // Debounce FSM state encoding (2 bits)
    localparam logic [1:0] ST_UP       = 2'd0;
    localparam logic [1:0] ST_ARM_DOWN = 2'd1;
    localparam logic [1:0] ST_DOWN     = 2'd2;
    localparam logic [1:0] ST_ARM_UP   = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage : pushbutton_pkg
`default_nettype wire

// File: rtl/pushbutton_conditioner_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One pushbutton channel: 2-FF synchroniser on the raw
//               active-low pin, 4-state debounce FSM with a saturating
//               stability counter, and registered press/release pulses.
// Ports       : clk         - system clock
//               reset       - asynchronous active-high reset
//               key_n_in    - raw pin, active-low, asynchronous to clk
//               key_level   - debounced level, 1 = pressed
//               key_press   - one-cycle pulse on key_level rising
//               key_release - one-cycle pulse on key_level falling
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import pushbutton_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] c_cnt_term = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_press;
    logic             r_release;
    logic             w_press_nxt;
    logic             w_release_nxt;

    // Plain two-flop chain; idle (released) pin level is 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ~r_sync2;

    // Saturating increment so the counter can never wrap
    assign w_cnt_inc = (r_cnt == c_cnt_term) ? r_cnt : r_cnt + c_cnt_one;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_UP: begin
                if (w_s) begin
                    w_state_nxt = ST_ARM_DOWN;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_DOWN: begin
                if (!w_s) begin
                    w_state_nxt = ST_UP;        // glitch rejected
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_term) begin
                    w_state_nxt = ST_DOWN;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_DOWN: begin
                if (!w_s) begin
                    w_state_nxt = ST_ARM_UP;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_ARM_UP: begin
                if (w_s) begin
                    w_state_nxt   = ST_DOWN;    // glitch rejected
                    w_cnt_nxt     = '0;
                end else if (r_cnt == c_cnt_term) begin
                    w_state_nxt   = ST_UP;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_UP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_UP;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Level is decoded from the registered state, so it changes on the
    // same edge that launches the press/release pulse.
    assign key_level   = (r_state == ST_DOWN) || (r_state == ST_ARM_UP);
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_conditioner
// Description : Conditions NUM_KEYS raw active-low pushbuttons: per-key
//               synchronise/debounce/pulse channels, sticky press capture
//               with write-one-to-clear, and a registered masked interrupt.
// Ports       : clk          - system clock
//               reset        - asynchronous active-high reset
//               key_n_in     - raw pins, active-low
//               key_level    - debounced levels, 1 = pressed
//               key_press    - one-cycle press pulses
//               key_release  - one-cycle release pulses
//               edge_capture - sticky press flags
//               edge_clear   - write-one-to-clear strobe for edge_capture
//               irq_mask     - per-key interrupt enable
//               irq          - registered |(edge_capture & irq_mask)
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_conditioner
    import pushbutton_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] edge_capture,
    input  logic [NUM_KEYS-1:0] edge_clear,
    input  logic [NUM_KEYS-1:0] irq_mask,
    output logic                irq
);

    logic [NUM_KEYS-1:0] r_capture;
    logic                r_irq;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .key_n_in    (key_n_in[gi]),
            .key_level   (key_level[gi]),
            .key_press   (key_press[gi]),
            .key_release (key_release[gi])
        );
    end

    // A new press overrides a simultaneous clear so no press is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_capture <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_capture <= key_press | (r_capture & ~edge_clear);
            r_irq     <= |(r_capture & irq_mask);
        end
    end

    assign edge_capture = r_capture;
    assign irq          = r_irq;

endmodule : pushbutton_conditioner
`default_nettype wire

// File: tb/tb_pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pushbutton_conditioner
// Description : Self-checking bench for pushbutton_conditioner with
//               DEBOUNCE_CYCLES=8, NUM_KEYS=4. A vector table walks through
//               press, bounce, release and capture/clear cases; hand-written
//               sequences cover reset mid-debounce and simultaneous presses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_conditioner;

    localparam int NK = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] edge_capture;
    logic [NK-1:0] edge_clear;
    logic [NK-1:0] irq_mask;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pushbutton_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .key_n_in     (key_n_in),
        .key_level    (key_level),
        .key_press    (key_press),
        .key_release  (key_release),
        .edge_capture (edge_capture),
        .edge_clear   (edge_clear),
        .irq_mask     (irq_mask),
        .irq          (irq)
    );

    typedef struct {
        int         n;
        logic [3:0] kn;
        logic [3:0] clr;
        logic [3:0] mask;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] cap;
        logic       irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic [3:0] kn, input logic [3:0] clr,
                       input logic [3:0] mask, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel,
                       input logic [3:0] cap, input logic irq_e);
        vec_t v;
        v.n = n; v.kn = kn; v.clr = clr; v.mask = mask; v.lvl = lvl;
        v.prs = prs; v.rel = rel; v.cap = cap; v.irq = irq_e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic [3:0] cap, input logic irq_e);
        chk({tag, ".key_level"},    key_level,    lvl);
        chk({tag, ".key_press"},    key_press,    prs);
        chk({tag, ".key_release"},  key_release,  rel);
        chk({tag, ".edge_capture"}, edge_capture, cap);
        chk({tag, ".irq"},          {3'b000, irq}, {3'b000, irq_e});
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        key_n_in   = 4'b1111;
        edge_clear = 4'b0000;
        irq_mask   = 4'b0001;

        //   n   kn       clr      mask     lvl      prs      rel      cap     irq
        // clean press on key 0
        add( 2, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add( 9, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add( 1, 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add( 1, 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        add( 1, 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        // bounce on key 1: low 5, high 2, then low held
        add( 5, 4'b1100, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add( 2, 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add( 9, 4'b1100, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add( 1, 4'b1100, 4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1);
        add( 1, 4'b1100, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1);
        // press then release key 2
        add(10, 4'b1000, 4'b0000, 4'b0001, 4'b0111, 4'b0100, 4'b0000, 4'b0011, 1'b1);
        add( 1, 4'b1000, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b1);
        add( 9, 4'b1100, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 1'b1);
        add( 1, 4'b1100, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0100, 4'b0111, 1'b1);
        add( 1, 4'b1100, 4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0111, 1'b1);
        // key 3: capture, clear others, release, re-press with collision
        add(10, 4'b0100, 4'b0000, 4'b0001, 4'b1011, 4'b1000, 4'b0000, 4'b0111, 1'b1);
        add( 1, 4'b0100, 4'b0000, 4'b0001, 4'b1011, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        add( 1, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        add(10, 4'b1100, 4'b0000, 4'b1000, 4'b0011, 4'b0000, 4'b1000, 4'b1000, 1'b1);
        add( 1, 4'b1100, 4'b0000, 4'b1000, 4'b0011, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        add(10, 4'b0100, 4'b0000, 4'b1000, 4'b1011, 4'b1000, 4'b0000, 4'b1000, 1'b1);
        add( 1, 4'b0100, 4'b1000, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        add( 1, 4'b0100, 4'b0000, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b1000, 1'b1);
        add( 1, 4'b0100, 4'b1000, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add( 1, 4'b0100, 4'b0000, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // reset state
        step(3);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            key_n_in   = tbl[i].kn;
            edge_clear = tbl[i].clr;
            irq_mask   = tbl[i].mask;
            step(tbl[i].n);
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel,
                    tbl[i].cap, tbl[i].irq);
        end
        edge_clear = 4'b0000;

        // Reset while key 0 sits in ARM_DOWN with cnt=5
        irq_mask = 4'b1111;
        key_n_in = 4'b0101;
        step(12);
        chk("pre_rst.key_level", key_level, 4'b1010);
        key_n_in = 4'b0100;
        step(7);
        chk("arm.key_level", key_level, 4'b1010);
        chk("arm.key_press", key_press, 4'b0000);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(2);
        rst = 1'b0;
        step(9);
        chk("rerel9.key_press", key_press, 4'b0000);
        chk("rerel9.key_level", key_level, 4'b0000);
        step(1);
        chk("rerel10.key_press", key_press, 4'b1011);
        chk("rerel10.key_level", key_level, 4'b1011);
        step(1);
        chk_all("rerel11", 4'b1011, 4'b0000, 4'b0000, 4'b1011, 1'b0);
        step(1);
        chk("rerel12.irq", {3'b000, irq}, 4'b0001);

        // Simultaneous presses on all keys
        key_n_in = 4'b1111;
        step(12);
        chk("allup.key_level", key_level, 4'b0000);
        edge_clear = 4'b1111;
        step(1);
        edge_clear = 4'b0000;
        step(1);
        chk("allclr.edge_capture", edge_capture, 4'b0000);
        key_n_in = 4'b0000;
        step(9);
        chk("sim9.key_press", key_press, 4'b0000);
        step(1);
        chk("sim10.key_press", key_press, 4'b1111);
        chk("sim10.key_level", key_level, 4'b1111);
        step(1);
        chk("sim11.key_press", key_press, 4'b0000);
        chk("sim11.edge_capture", edge_capture, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pushbutton_conditioner
`default_nettype wire

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
- Conditions the raw active-low KEY pins before they reach the system's pushbutton parallel port.
- Performs 2-FF synchronisation, per-key debouncing, press/release pulse generation, and sticky press capture with an optional interrupt output.
- Sits between the board KEY pins and the system's pushbutton input, running on the 100 MHz system clock.

Parameters:
- NUM_KEYS, 4: number of independent pushbutton channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples needed to accept a level change (10 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_n_in  in  NUM_KEYS  raw pushbutton pins, active-low, asynchronous to clk
- key_level  out  NUM_KEYS  debounced level, active-high (1 = pressed)
- key_press  out  NUM_KEYS  one-cycle pulse when key_level rises
- key_release  out  NUM_KEYS  one-cycle pulse when key_level falls
- edge_capture  out  NUM_KEYS  sticky press flags
- edge_clear  in  NUM_KEYS  write-one-to-clear for edge_capture; single-cycle strobe
- irq_mask  in  NUM_KEYS  per-key interrupt enable
- irq  out  1  |(edge_capture & irq_mask), registered

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous, active-high, named reset; clock named clk.
- Reset values:
  - Synchroniser flops = all 1s (released).
  - key_level, key_press, key_release, edge_capture, irq = 0.
  - All counters = 0.
  - All FSMs in UP.
- Synchroniser:
  - 2-FF chain per bit, then inverted; sample s = ~sync2.
  - No logic is placed between the two flops.
- Per-key FSM, 4 states, encoded in 2 bits:
  - UP: key_level=0. s=1 → ARM_DOWN with cnt=1. Otherwise stay, cnt=0.
  - ARM_DOWN: s=0 → UP, cnt=0 (glitch rejected). s=1 and cnt==DEBOUNCE_CYCLES-1 → DOWN, cnt=0, key_press=1 next cycle. Else cnt+1.
  - DOWN: key_level=1. s=0 → ARM_UP with cnt=1. Otherwise stay.
  - ARM_UP: symmetric to ARM_DOWN. s=1 → DOWN. On reaching terminal count → UP and key_release=1.
- Latency:
  - key_level changes exactly DEBOUNCE_CYCLES edges after s first differs, with s held constant throughout.
  - Measured from the raw pin, the delay is DEBOUNCE_CYCLES+2 edges.
- Pulses:
  - key_press and key_release are registered, exactly one cycle wide, and coincident with the key_level transition cycle.
  - key_press and key_release are never both high on the same key.
- Counter:
  - Saturates at DEBOUNCE_CYCLES-1; it never wraps.
  - It is cleared on every state change and on every glitch.
- edge_capture[i]:
  - Set by key_press[i]; cleared by edge_clear[i].
  - Set and clear on the same cycle → set wins, so no press is lost.
  - Clear with no flag set → no effect.
- irq:
  - Registered one cycle after edge_capture & irq_mask changes.
  - Deasserts one cycle after the last masked flag clears.
- Channel independence:
  - Keys are fully independent; simultaneous presses on several keys each generate their own pulse in the same cycle.
- Reset mid-operation:
  - Asserting reset during ARM_* or DOWN returns all state to reset values immediately.
  - No release pulse is emitted.
  - After reset deassertion, a key still held is re-debounced and generates a fresh key_press after DEBOUNCE_CYCLES+2 edges.

Decomposition:
- Package pushbutton_pkg holds:
  - State encoding localparams: ST_UP=2'd0, ST_ARM_DOWN=2'd1, ST_DOWN=2'd2, ST_ARM_UP=2'd3.
  - DEFAULT_DEBOUNCE_CYCLES = 1000000.
- Sub-module debounce_channel (single bit: synchroniser, FSM, counter, press/release pulses) is instantiated NUM_KEYS times via generate.
- Capture register and irq logic live in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8 and NUM_KEYS=4.
- Clean press: key_n_in[0] 1→0 and held → key_level[0]=1 and a single key_press[0] pulse exactly 10 edges later. edge_capture=4'b0001. With irq_mask=4'b0001, irq=1 one cycle later.
- Bounce rejection: key_n_in[1] low for 5 cycles, high 2, then low held → no output during the bounce. key_level[1] rises 10 edges after the final falling edge.
- Release: hold key 2 down, then raise key_n_in[2] → key_release[2] pulse 10 edges later; key_level[2]=0; edge_capture unchanged.
- Set/clear collision: edge_capture[3]=1, then a new key_press[3] in the same cycle as edge_clear[3]=1 → edge_capture[3] stays 1. A following edge_clear alone gives 0, and irq drops one cycle later.
- Reset mid-debounce: assert reset while key 0 is in ARM_DOWN with cnt=5 → all outputs 0 asynchronously. Release reset with the key held → key_press[0] 10 edges after deassertion.
- Simultaneous keys: key_n_in=4'b0000 at once → key_press=4'b1111 in one cycle, and edge_capture=4'b1111.
